// File: rtl/framestore_arbiter_pkg.sv
// Shared definitions for the frame-store arbiter: bus widths, FSM state
// codes, owner codes and a helper that sizes the VDU wait counter.
package framestore_arbiter_pkg;

  localparam int FS_ADDR_W       = 18;  // 256K x 32-bit words
  localparam int FS_DATA_W       = 32;
  localparam int FS_VDU_DEADLINE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_VDU = 2'd0,
    OWN_DRW = 2'd1,
    OWN_HST = 2'd2
  } owner_e;

  // The wait counter must be able to hold deadline+1, the value that flags
  // a late VDU fetch.
  function automatic int cnt_width(input int deadline);
    return (deadline + 2 > 2) ? $clog2(deadline + 2) : 1;
  endfunction

endpackage

// File: rtl/framestore_arbiter_rr_select.sv
// Two-way round-robin picker between the drawing engine and the host bus.
// When both request, the one that did not own the last access wins.
module fsa_rr_select
  import framestore_arbiter_pkg::*;
(
  input  logic   drw_req_i,
  input  logic   hst_req_i,
  input  owner_e last_i,
  output logic   valid_o,
  output owner_e winner_o
);

  // Pick the winner from the pending requests and the last owner.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    valid_o  = drw_req_i | hst_req_i;
    winner_o = OWN_DRW;
    if (drw_req_i && hst_req_i) begin
      winner_o = (last_i == OWN_DRW) ? OWN_HST : OWN_DRW;
    end else if (hst_req_i) begin
      winner_o = OWN_HST;
    end
  end

endmodule

// File: rtl/framestore_arbiter.sv
// Frame-store memory port arbiter. The VDU has fixed top priority (reads
// only); the drawing engine and host bus share round-robin. One access at a
// time, never preempted. A sticky flag records any VDU fetch that waited
// longer than its deadline.
module framestore_arbiter
  import framestore_arbiter_pkg::*;
#(
  parameter int ADDR_W       = FS_ADDR_W,
  parameter int DATA_W       = FS_DATA_W,
  parameter int VDU_DEADLINE = FS_VDU_DEADLINE
) (
  input  logic                clk,
  input  logic                reset,
  // VDU controller (read-only)
  input  logic                vdu_req,
  input  logic [ADDR_W-1:0]   vdu_address,
  output logic                vdu_ack,
  output logic [DATA_W-1:0]   vdu_data,
  // drawing engine
  input  logic                drw_req,
  input  logic                drw_wr,
  input  logic [ADDR_W-1:0]   drw_address,
  input  logic [DATA_W/8-1:0] drw_be,
  input  logic [DATA_W-1:0]   drw_wdata,
  output logic                drw_ack,
  output logic [DATA_W-1:0]   drw_rdata,
  // host bus
  input  logic                hst_req,
  input  logic                hst_wr,
  input  logic [ADDR_W-1:0]   hst_address,
  input  logic [DATA_W/8-1:0] hst_be,
  input  logic [DATA_W-1:0]   hst_wdata,
  output logic                hst_ack,
  output logic [DATA_W-1:0]   hst_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  // status
  output logic                vdu_late
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = cnt_width(VDU_DEADLINE);
  localparam logic [CNT_W-1:0] CNT_LATE = CNT_W'(VDU_DEADLINE + 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              rr_last_q, rr_last_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                vdu_ack_q, vdu_ack_d;
  logic                drw_ack_q, drw_ack_d;
  logic                hst_ack_q, hst_ack_d;
  logic [DATA_W-1:0]   vdu_data_q, vdu_data_d;
  logic [DATA_W-1:0]   drw_rdata_q, drw_rdata_d;
  logic [DATA_W-1:0]   hst_rdata_q, hst_rdata_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                vdu_late_q, vdu_late_d;

  logic                rr_valid;
  owner_e              rr_winner;

  fsa_rr_select u_rr_select (
    .drw_req_i (drw_req),
    .hst_req_i (hst_req),
    .last_i    (rr_last_q),
    .valid_o   (rr_valid),
    .winner_o  (rr_winner)
  );

  // State register: synchronous reset abandons any access in flight.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_VDU;
      rr_last_q     <= OWN_HST;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      vdu_ack_q     <= 1'b0;
      drw_ack_q     <= 1'b0;
      hst_ack_q     <= 1'b0;
      vdu_data_q    <= '0;
      drw_rdata_q   <= '0;
      hst_rdata_q   <= '0;
      wait_cnt_q    <= '0;
      vdu_late_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_last_q     <= rr_last_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_be_q      <= mem_be_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      vdu_ack_q     <= vdu_ack_d;
      drw_ack_q     <= drw_ack_d;
      hst_ack_q     <= hst_ack_d;
      vdu_data_q    <= vdu_data_d;
      drw_rdata_q   <= drw_rdata_d;
      hst_rdata_q   <= hst_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
      vdu_late_q    <= vdu_late_d;
    end
  end

  // Next-state logic: grant in IDLE, hold the bus in BUSY, pulse ack in DONE,
  // and track how long a pending VDU request has been kept waiting.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_be_d      = mem_be_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    vdu_ack_d     = 1'b0;
    drw_ack_d     = 1'b0;
    hst_ack_d     = 1'b0;
    vdu_data_d    = vdu_data_q;
    drw_rdata_d   = drw_rdata_q;
    hst_rdata_d   = hst_rdata_q;
    wait_cnt_d    = wait_cnt_q;
    vdu_late_d    = vdu_late_q;

    case (state_q)
      ST_IDLE: begin
        if (vdu_req) begin
          owner_d       = OWN_VDU;
          mem_req_d     = 1'b1;
          mem_wr_d      = 1'b0;
          mem_be_d      = '1;
          mem_address_d = vdu_address;
          mem_wdata_d   = '0;
          state_d       = ST_BUSY;
        end else if (rr_valid) begin
          owner_d   = rr_winner;
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
          if (rr_winner == OWN_HST) begin
            mem_wr_d      = hst_wr;
            mem_be_d      = hst_be;
            mem_address_d = hst_address;
            mem_wdata_d   = hst_wdata;
          end else begin
            mem_wr_d      = drw_wr;
            mem_be_d      = drw_be;
            mem_address_d = drw_address;
            mem_wdata_d   = drw_wdata;
          end
        end
      end

      ST_BUSY: begin
        // mem_* stay frozen until the memory completes the access.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          state_d   = ST_DONE;
          case (owner_q)
            OWN_VDU: begin
              vdu_data_d = mem_rdata;
              vdu_ack_d  = 1'b1;
            end
            OWN_DRW: begin
              if (!mem_wr_q) drw_rdata_d = mem_rdata;
              drw_ack_d = 1'b1;
            end
            default: begin
              if (!mem_wr_q) hst_rdata_d = mem_rdata;
              hst_ack_d = 1'b1;
            end
          endcase
        end
      end

      ST_DONE: begin
        if (owner_q != OWN_VDU) rr_last_d = owner_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A VDU request is "waiting" unless it is being granted now or already
    // owns the bus.
    if (state_q == ST_IDLE && vdu_req) begin
      wait_cnt_d = '0;
    end else if (vdu_req && !(state_q != ST_IDLE && owner_q == OWN_VDU)) begin
      if (wait_cnt_q != CNT_LATE) wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (wait_cnt_d == CNT_LATE) vdu_late_d = 1'b1;
  end

  assign vdu_ack     = vdu_ack_q;
  assign vdu_data    = vdu_data_q;
  assign drw_ack     = drw_ack_q;
  assign drw_rdata   = drw_rdata_q;
  assign hst_ack     = hst_ack_q;
  assign hst_rdata   = hst_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_be      = mem_be_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign vdu_late    = vdu_late_q;

endmodule
